// File: rtl/alus_shift_arbiter.sv
// Round-robin arbiter sharing one shift/rotate unit between two requesters.
// Latency: accept in cycle T, rsp_valid rises at T+ISSUE_CYCLES+1.
// Backpressure: no request is accepted outside IDLE; the response holds until rsp_ready.
module alus_shift_arbiter #(
    parameter int A_W          = 3,
    parameter int CNT_W        = 3,
    parameter int S_W          = 8,
    parameter int ISSUE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [A_W-1:0]   req0_A,
    input  logic [CNT_W-1:0] req0_Cnt,
    input  logic [1:0]       req0_sel,
    input  logic [A_W-1:0]   req1_A,
    input  logic [CNT_W-1:0] req1_Cnt,
    input  logic [1:0]       req1_sel,
    output logic [A_W-1:0]   alu_A,
    output logic [CNT_W-1:0] alu_Cnt,
    output logic [1:0]       alu_sel,
    input  logic [S_W-1:0]   alu_S,
    input  logic             alu_Co,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [S_W-1:0]   rsp_S,
    output logic             rsp_Co,
    output logic             busy
);

    localparam int              IC_W    = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
    localparam logic [IC_W-1:0] IC_LOAD = IC_W'(ISSUE_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]       r_state;
    logic             r_last_grant;
    logic [IC_W-1:0]  r_cnt;
    logic             r_id;
    logic [A_W-1:0]   r_alu_A;
    logic [CNT_W-1:0] r_alu_Cnt;
    logic [1:0]       r_alu_sel;
    logic             r_rsp_id;
    logic [S_W-1:0]   r_rsp_S;
    logic             r_rsp_Co;

    logic             w_grant;
    logic             w_fire;

    // Pick the requester to serve: a lone valid wins, a tie goes to whoever did not win last.
    always_comb begin
        w_grant = 1'b0;
        case (req_valid)
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;
            default: w_grant = 1'b0;
        endcase
    end

    // Ready is offered only to the granted, currently-valid requester, so a dropped request is never taken.
    assign w_fire    = (r_state == S_IDLE) && req_valid[w_grant];
    assign req_ready = w_fire ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

    assign alu_A     = r_alu_A;
    assign alu_Cnt   = r_alu_Cnt;
    assign alu_sel   = r_alu_sel;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_S     = r_rsp_S;
    assign rsp_Co    = r_rsp_Co;
    assign busy      = (r_state != S_IDLE);

    // Transaction sequencing: latch operands on accept, hold them through ISSUE, capture result, wait for drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_id         <= 1'b0;
            r_alu_A      <= '0;
            r_alu_Cnt    <= '0;
            r_alu_sel    <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_S      <= '0;
            r_rsp_Co     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        r_alu_A      <= w_grant ? req1_A   : req0_A;
                        r_alu_Cnt    <= w_grant ? req1_Cnt : req0_Cnt;
                        r_alu_sel    <= w_grant ? req1_sel : req0_sel;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= IC_LOAD;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_cnt == '0) begin
                        r_rsp_S  <= alu_S;
                        r_rsp_Co <= alu_Co;
                        r_rsp_id <= r_id;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    // Returning to IDLE here means no grant can coincide with the response handshake.
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
